// File: rtl/delay_line_scheduler.sv
// rtl/delay_line_scheduler.sv - slot timing, recirculation and single-word access for an acoustic delay line tank
//
// Purpose: divides clk into bit slots, tracks the word/bit slot leaving the tank,
// recirculates line_in to line_out (spacing slot forced to 0), and serialises one
// read or write request at a time into the matching word slot.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   line_in             demodulated bit leaving the tank (sampled on bit_tick)
//   line_out            registered bit driven into the modulator
//   bit_tick            one-cycle strobe marking the slot update edge
//   slot_word/slot_bit  slot currently emerging from the tank
//   req_*               request handshake (write flag, word address, write data)
//   rsp_valid/rsp_rdata completion pulse with the word contents before the access

module delay_line_scheduler #(
    parameter int CLKS_PER_BIT = 190,
    parameter int WORDS        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     line_in,
    output logic                     line_out,
    output logic                     bit_tick,
    output logic [$clog2(WORDS)-1:0] slot_word,
    output logic [5:0]               slot_bit,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(WORDS)-1:0] req_addr,
    input  logic [34:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [34:0]              rsp_rdata
);

    localparam int AW        = $clog2(WORDS);
    localparam int DIV_W     = $clog2(CLKS_PER_BIT);
    localparam int WORD_BITS = 35;

    localparam logic [5:0] SPACE_BIT = 6'd35;
    localparam logic [5:0] LAST_BIT  = 6'd34;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE,
        S_RESP
    } state_t;

    state_t                 state;
    logic [DIV_W-1:0]       div;
    logic                   cap_write;
    logic [AW-1:0]          prev_word;
    logic [WORD_BITS-1:0]   cap_wdata;
    logic [WORD_BITS-1:0]   shreg;

    assign bit_tick = (div == DIV_W'(CLKS_PER_BIT - 1));

    // Bit slot divider and slot position.
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            slot_bit  <= '0;
            slot_word <= '0;
        end else if (bit_tick) begin
            div <= '0;
            if (slot_bit == SPACE_BIT) begin
                slot_bit  <= '0;
                slot_word <= slot_word + AW'(1);
            end else begin
                slot_bit <= slot_bit + 6'd1;
            end
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Access sequencer and modulator drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            line_out  <= 1'b0;
            cap_write <= 1'b0;
            prev_word <= '0;
            cap_wdata <= '0;
            shreg     <= '0;
        end else begin
            rsp_valid <= 1'b0;

            // Write data is pre-shifted so its MSB always lines up with the
            // next active slot; ACTIVE only ever sees slot bits 0..34.
            if (bit_tick) begin
                if (slot_bit == SPACE_BIT) begin
                    line_out <= 1'b0;
                end else if (state == S_ACTIVE && cap_write) begin
                    line_out <= cap_wdata[WORD_BITS-1];
                end else begin
                    line_out <= line_in;
                end
            end

            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cap_write <= req_write;
                        cap_wdata <= req_wdata;
                        // The spacing slot of the preceding word is the entry point.
                        prev_word <= req_addr - AW'(1);
                        req_ready <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bit_tick && slot_bit == SPACE_BIT && slot_word == prev_word) begin
                        state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (bit_tick) begin
                        shreg     <= {shreg[WORD_BITS-2:0], line_in};
                        cap_wdata <= {cap_wdata[WORD_BITS-2:0], 1'b0};
                        if (slot_bit == LAST_BIT) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= {shreg[WORD_BITS-2:0], line_in};
                            state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// tb/tb_delay_line_scheduler.sv - self-checking bench for delay_line_scheduler with a modelled tank

module tb_delay_line_scheduler;

    localparam int CPB   = 4;
    localparam int WORDS = 4;
    localparam int AW    = 2;
    localparam int R     = 36 * WORDS;
    localparam int LAT_LIM = (R + 40) * CPB + 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          line_in;
    logic          line_out;
    logic          bit_tick;
    logic [AW-1:0] slot_word;
    logic [5:0]    slot_bit;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [34:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [34:0]   rsp_rdata;

    delay_line_scheduler #(.CLKS_PER_BIT(CPB), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .line_in   (line_in),
        .line_out  (line_out),
        .bit_tick  (bit_tick),
        .slot_word (slot_word),
        .slot_bit  (slot_bit),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    // Tank: R-1 stages clocked on bit_tick from line_out back to line_in.
    logic [R-2:0] tank = '0;
    logic         tank_clr = 1'b0;
    logic         force_one = 1'b0;
    always @(posedge clk) begin
        if (tank_clr) tank <= '0;
        else if (bit_tick) tank <= {tank[R-3:0], line_out};
    end
    assign line_in = force_one ? 1'b1 : tank[R-2];

    // Independent time base: edges since reset release; tick edges are multiples of CPB.
    int edges = 0;
    int ticks_done = 0;
    always @(posedge clk) begin
        if (rst) begin
            edges      <= 0;
            ticks_done <= 0;
        end else begin
            edges <= edges + 1;
            if ((edges + 1) % CPB == 0) ticks_done <= ticks_done + 1;
        end
    end

    logic [34:0] mem [WORDS];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] rnd35();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[34:0];
    endfunction

    // Edge after which rsp_valid must be visible for a request accepted at edge ka.
    function automatic int exp_kr(input int ka, input int a);
        int target, s0;
        target = ((a + WORDS - 1) % WORDS) * 36 + 35;
        s0 = ka / CPB - 1;
        if (s0 < 0) s0 = 0;
        for (int s = s0; s < s0 + 2 * R + 2; s++)
            if (s % R == target && (s + 1) * CPB > ka) return (s + 36) * CPB;
        return -1;
    endfunction

    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [34:0] d,
                          output logic [34:0] rd, output int ka, output int kr, output bit ok);
        int n;
        ok = 1'b1; rd = '0; ka = 0; kr = 0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        if (!req_ready) begin ok = 1'b0; req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        ka = edges;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < LAT_LIM) begin @(negedge clk); n++; end
        if (!rsp_valid) begin ok = 1'b0; return; end
        kr = edges;
        rd = rsp_rdata;
        @(negedge clk);
    endtask

    task automatic txn(input string nm, input logic w, input logic [AW-1:0] a,
                       input logic [34:0] d, input logic [34:0] exp_rd);
        logic [34:0] rd;
        int ka, kr;
        bit ok;
        do_req(w, a, d, rd, ka, kr, ok);
        chk({nm, " completed"}, 64'(ok), 64'd1);
        if (ok) begin
            chk({nm, " rdata"}, 64'(rd), 64'(exp_rd));
            chk({nm, " rsp_edge"}, 64'(kr), 64'(exp_kr(ka, a)));
        end
        if (w) mem[a] = d;
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [34:0]   d;
        logic [34:0]   exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, bad_tick, bad_slot, ka, kr, sp_bad, dt_bad, seen, last_t, s, bad;
        bit ok;
        logic [34:0] rd, old, d;
        logic [R-2:0] tmask, texp;

        tbl[0] = '{1'b1, 2'd0, 35'h1_2345_6789, 35'h0};
        tbl[1] = '{1'b1, 2'd1, 35'h7_0000_0001, 35'h0};
        tbl[2] = '{1'b0, 2'd0, 35'h0,           35'h1_2345_6789};
        tbl[3] = '{1'b1, 2'd2, 35'h0,           35'h5_5555_5555};
        tbl[4] = '{1'b0, 2'd2, 35'h0,           35'h0};
        tbl[5] = '{1'b1, 2'd3, 35'h4_0000_0000, 35'h0};
        tbl[6] = '{1'b0, 2'd3, 35'h0,           35'h4_0000_0000};
        tbl[7] = '{1'b1, 2'd1, 35'h2_AAAA_AAAA, 35'h7_0000_0001};
        tbl[8] = '{1'b0, 2'd1, 35'h0,           35'h2_AAAA_AAAA};
        for (int i = 0; i < WORDS; i++) mem[i] = '0;

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset line_out", 64'(line_out), 64'd0);
        chk("reset bit_tick", 64'(bit_tick), 64'd0);
        chk("reset slot", 64'({slot_word, slot_bit}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("release req_ready", 64'(req_ready), 64'd1);
        chk("release line_out", 64'(line_out), 64'd0);
        chk("release rsp_valid", 64'(rsp_valid), 64'd0);
        n = 1;
        while (!bit_tick && n < 20) begin @(negedge clk); n++; end
        chk("first tick cycles", 64'(n), 64'd3);
        bad_tick = 0; bad_slot = 0;
        for (int i = 0; i < 40 * CPB; i++) begin
            if (bit_tick !== ((edges + 1) % CPB == 0)) bad_tick++;
            if (slot_word !== AW'((ticks_done % R) / 36) || slot_bit !== 6'((ticks_done % R) % 36)) bad_slot++;
            if (ticks_done == 36 && (edges % CPB) == 0)
                chk("slot wrap to word 1", 64'({slot_word, slot_bit}), 64'({2'd1, 6'd0}));
            @(negedge clk);
        end
        chk("bit_tick cadence", 64'(bad_tick), 64'd0);
        chk("slot sequence", 64'(bad_slot), 64'd0);

        // Write then read
        txn("wr2", 1'b1, 2'd2, 35'h5_5555_5555, mem[2]);
        txn("rd2", 1'b0, 2'd2, 35'h0, 35'h5_5555_5555);
        txn("rd1", 1'b0, 2'd1, 35'h0, 35'h0);
        txn("rd2 again", 1'b0, 2'd2, 35'h0, 35'h5_5555_5555);

        // Table vectors
        for (int i = 0; i < 9; i++) txn($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);

        // Random against the word model
        for (int i = 0; i < 10; i++) begin
            logic          w;
            logic [AW-1:0] a;
            repeat ($urandom_range(0, R * CPB - 1)) @(negedge clk);
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom_range(0, WORDS - 1));
            d = rnd35();
            txn($sformatf("rand%0d", i), w, a, d, mem[a]);
        end

        // Minimum latency: accepted on the edge before the boundary tick
        n = 0;
        while (!(ticks_done % R == 35 && (edges + 2) % CPB == 0) && n < 2 * R * CPB) begin @(negedge clk); n++; end
        do_req(1'b0, 2'd1, 35'h0, rd, ka, kr, ok);
        chk("min lat edges", 64'(kr - ka), 64'(35 * CPB + 1));
        chk("min lat rdata", 64'(rd), 64'(mem[1]));

        // Maximum latency: accepted on the boundary tick itself
        n = 0;
        while (!(ticks_done % R == 35 && (edges + 1) % CPB == 0) && n < 2 * R * CPB) begin @(negedge clk); n++; end
        do_req(1'b0, 2'd1, 35'h0, rd, ka, kr, ok);
        chk("max lat edges", 64'(kr - ka), 64'((R + 35) * CPB));

        // Same-word wait: addr 0 accepted while slot (0,10) is current
        n = 0;
        while (!(ticks_done % R == 10 && (edges + 1) % CPB == 1) && n < 2 * R * CPB) begin @(negedge clk); n++; end
        do_req(1'b0, 2'd0, 35'h0, rd, ka, kr, ok);
        chk("same word slots", 64'(kr / CPB - ka / CPB), 64'(R + 25));
        chk("same word rsp_edge", 64'(kr), 64'(exp_kr(ka, 0)));
        chk("same word rdata", 64'(rd), 64'(mem[0]));

        // Busy backpressure
        req_write = 1'b0; req_addr = 2'd1; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 1000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        ka = edges;
        d = rnd35();
        req_write = 1'b1; req_addr = 2'd2; req_wdata = d;
        bad = 0; n = 0;
        while (!rsp_valid && n < LAT_LIM) begin
            if (req_ready) bad++;
            @(negedge clk); n++;
        end
        chk("bp ready low in wait", 64'(bad), 64'd0);
        chk("bp first rsp", 64'(rsp_valid), 64'd1);
        chk("bp ready low in resp", 64'(req_ready), 64'd0);
        chk("bp first rdata", 64'(rsp_rdata), 64'(mem[1]));
        chk("bp first rsp_edge", 64'(edges), 64'(exp_kr(ka, 1)));
        @(negedge clk);
        chk("bp ready in idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ka = edges;
        req_valid = 1'b0;
        chk("bp second accepted", 64'(req_ready), 64'd0);
        n = 0;
        while (!rsp_valid && n < LAT_LIM) begin @(negedge clk); n++; end
        chk("bp second rdata", 64'(rsp_rdata), 64'(mem[2]));
        chk("bp second rsp_edge", 64'(edges), 64'(exp_kr(ka, 2)));
        mem[2] = d;
        @(negedge clk);

        // Reset mid-write of word 3 after slots (3,0..19) have been processed
        n = 0;
        while (ticks_done % R != 50 && n < 2 * R * CPB) begin @(negedge clk); n++; end
        old = mem[3];
        req_write = 1'b1; req_addr = 2'd3; req_wdata = 35'h7_FFFF_FFFF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        bad = 0; n = 0;
        while (ticks_done % R != 3 * 36 + 20 && n < 2 * R * CPB) begin
            if (rsp_valid) bad++;
            @(negedge clk); n++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid || req_ready) bad++;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midwrite no rsp", 64'(bad), 64'd0);
        chk("midwrite ready after", 64'(req_ready), 64'd1);
        tmask = '0; texp = '0;
        for (int i = 0; i <= 18; i++) begin tmask[18 - i] = 1'b1; texp[18 - i] = 1'b1; end
        for (int i = 20; i <= 34; i++) begin tmask[162 - i] = 1'b1; texp[162 - i] = old[34 - i]; end
        chk("midwrite written bits", 64'((tank & tmask) & {{(R-20){1'b0}}, {19{1'b1}}}), 64'(texp[18:0]));
        chk("midwrite old bits", 64'(((tank & tmask) >> 128) & 64'h7FFF), 64'((texp >> 128) & 64'h7FFF));
        tank_clr = 1'b1;
        @(negedge clk);
        tank_clr = 1'b0;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) bad++;
            @(negedge clk);
        end
        chk("post reset no rsp", 64'(bad), 64'd0);

        // Spacing slot with the line forced high
        force_one = 1'b1;
        last_t = ticks_done; seen = 0; sp_bad = 0; dt_bad = 0; n = 0;
        while (seen < R + 36 && n < (R + 40) * CPB) begin
            @(negedge clk); n++;
            if (ticks_done != last_t) begin
                last_t = ticks_done;
                s = ticks_done - 1;
                if (s % 36 == 35) begin
                    if (line_out !== 1'b0) sp_bad++;
                end else if (line_out !== 1'b1) begin
                    dt_bad++;
                end
                seen++;
            end
        end
        chk("spacing slots zero", 64'(sp_bad), 64'd0);
        chk("recirculated ones", 64'(dt_bad), 64'd0);
        chk("spacing ticks seen", 64'(seen), 64'(R + 36));
        force_one = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
